music_sequencer: RTL and testbench

- Score-playback stage directly upstream of the speaker top. Produces its `note_div` and `volume` inputs.
- Walks a note score held in an external synchronous ROM and holds each note for a programmable number of tempo ticks.
- Handles play/pause/stop and volume up/down from single-cycle button pulses (pulses are already debounced and one-pulsed).

---
 rtl/music_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_music_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/music_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : music_sequencer
//  Brief    : Score playback stage. Reads an external synchronous ROM one
//             word at a time and holds each note for duration*TICK_CYCLES
//             clocks. Drives note_div/volume for the speaker stage.
//             Play/pause/stop and volume come from single-cycle pulses.
//  Options  : define MUSIC_LOOP_EN to restart from address 0 at the end of
//             the score instead of returning to idle.
//  Revision : 1.0 - initial release
// ============================================================================
module music_sequencer #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int TICK_CYCLES = 12_500_000,
  parameter int ADDR_W      = 5,
  parameter int VOL_RESET   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play_btn,
  input  logic              stop_btn,
  input  logic              vol_up,
  input  logic              vol_down,
  output logic [ADDR_W-1:0] score_addr,
  input  logic [7:0]        score_data,
  output logic [21:0]       note_div,
  output logic [3:0]        volume,
  output logic              playing,
  output logic              done
);

  localparam int                  c_tick_w    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_CYCLES - 1);
  localparam logic [ADDR_W-1:0]   c_addr_last = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [21:0]         r_note_div, w_note_nxt;
  logic [c_tick_w-1:0] r_tick, w_tick_nxt;
  logic [3:0]          r_dur, w_dur_nxt;
  logic                r_done, w_done_nxt;
  logic                w_end;
  logic [3:0]          r_vol;

  // Divider per note code: CLK_FREQ / f, truncated; code 0 is a rest.
  function automatic logic [21:0] note_lut(input logic [3:0] code);
    case (code)
      4'd1:    note_lut = 22'(CLK_FREQ / 262);
      4'd2:    note_lut = 22'(CLK_FREQ / 294);
      4'd3:    note_lut = 22'(CLK_FREQ / 330);
      4'd4:    note_lut = 22'(CLK_FREQ / 349);
      4'd5:    note_lut = 22'(CLK_FREQ / 392);
      4'd6:    note_lut = 22'(CLK_FREQ / 440);
      4'd7:    note_lut = 22'(CLK_FREQ / 494);
      4'd8:    note_lut = 22'(CLK_FREQ / 523);
      4'd9:    note_lut = 22'(CLK_FREQ / 587);
      4'd10:   note_lut = 22'(CLK_FREQ / 659);
      4'd11:   note_lut = 22'(CLK_FREQ / 698);
      4'd12:   note_lut = 22'(CLK_FREQ / 784);
      4'd13:   note_lut = 22'(CLK_FREQ / 880);
      4'd14:   note_lut = 22'(CLK_FREQ / 988);
      4'd15:   note_lut = 22'(CLK_FREQ / 1047);
      default: note_lut = 22'd0;
    endcase
  endfunction

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_note_div <= '0;
      r_tick     <= '0;
      r_dur      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_note_div <= w_note_nxt;
      r_tick     <= w_tick_nxt;
      r_dur      <= w_dur_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state logic; end-of-score and stop override the per-state result.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_note_nxt  = r_note_div;
    w_tick_nxt  = r_tick;
    w_dur_nxt   = r_dur;
    w_done_nxt  = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (play_btn) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = '0;
        end
      end
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (score_data[3:0] == 4'd0) begin
          w_end = 1'b1;
        end else begin
          w_note_nxt  = note_lut(score_data[7:4]);
          w_dur_nxt   = score_data[3:0];
          w_tick_nxt  = '0;
          w_state_nxt = S_PLAY;
        end
      end
      S_PLAY: begin
        // The cycle on which pause is requested still counts as played.
        if (r_tick == c_tick_last) begin
          w_tick_nxt = '0;
          w_dur_nxt  = r_dur - 4'd1;
        end else begin
          w_tick_nxt = r_tick + c_tick_w'(1);
        end
        // A finishing note wins over a pause request so PAUSE never holds dur 0.
        if (r_tick == c_tick_last && r_dur == 4'd1) begin
          if (r_addr == c_addr_last) begin
            w_end = 1'b1;
          end else begin
            w_addr_nxt  = r_addr + ADDR_W'(1);
            w_state_nxt = S_FETCH;
          end
        end else if (play_btn) begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (play_btn) w_state_nxt = S_PLAY;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_end) begin
      w_done_nxt = 1'b1;
      w_addr_nxt = '0;
      w_note_nxt = '0;
      w_tick_nxt = '0;
      w_dur_nxt  = '0;
`ifdef MUSIC_LOOP_EN
      w_state_nxt = S_FETCH;
`else
      w_state_nxt = S_IDLE;
`endif
    end

    if (stop_btn) begin
      w_state_nxt = S_IDLE;
      w_addr_nxt  = '0;
      w_note_nxt  = '0;
      w_tick_nxt  = '0;
      w_dur_nxt   = '0;
      w_done_nxt  = 1'b0;
    end
  end

  // Saturating volume register; simultaneous up/down cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vol <= 4'(VOL_RESET);
    end else if (vol_up && !vol_down && r_vol != 4'hF) begin
      r_vol <= r_vol + 4'd1;
    end else if (vol_down && !vol_up && r_vol != 4'h0) begin
      r_vol <= r_vol - 4'd1;
    end
  end

  assign playing    = (r_state == S_FETCH) || (r_state == S_LOAD) || (r_state == S_PLAY);
  assign volume     = (playing && r_note_div != 22'd0) ? r_vol : 4'd0;
  assign note_div   = r_note_div;
  assign score_addr = r_addr;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_music_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_music_sequencer
//  Brief    : Directed self-checking bench for music_sequencer with
//             TICK_CYCLES=4 and a behavioural synchronous score ROM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_music_sequencer;

  localparam int          c_tick  = 4;
  localparam logic [21:0] c_div_a4 = 22'd227272;
  localparam logic [21:0] c_div_c5 = 22'd191204;
  localparam logic [21:0] c_div_c4 = 22'd381679;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        play_btn = 1'b0;
  logic        stop_btn = 1'b0;
  logic        vol_up   = 1'b0;
  logic        vol_down = 1'b0;
  logic [4:0]  score_addr;
  logic [7:0]  score_data;
  logic [21:0] note_div;
  logic [3:0]  volume;
  logic        playing;
  logic        done;

  logic [7:0]  rom [32];
  int          checks = 0;
  int          errors = 0;

  music_sequencer #(
    .CLK_FREQ    (100_000_000),
    .TICK_CYCLES (c_tick),
    .ADDR_W      (5),
    .VOL_RESET   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .play_btn   (play_btn),
    .stop_btn   (stop_btn),
    .vol_up     (vol_up),
    .vol_down   (vol_down),
    .score_addr (score_addr),
    .score_data (score_data),
    .note_div   (note_div),
    .volume     (volume),
    .playing    (playing),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) score_data <= rom[score_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Packed view {playing, done, score_addr, volume, note_div}.
  function automatic logic [63:0] snap();
    return {31'd0, playing, done, score_addr, volume, note_div};
  endfunction

  function automatic logic [63:0] pack(input logic pl, input logic dn, input logic [4:0] a,
                                       input logic [3:0] v, input logic [21:0] d);
    return {31'd0, pl, dn, a, v, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_play();
    play_btn = 1'b1; step(); play_btn = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_btn = 1'b1; step(); stop_btn = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
  endtask

  // Bounded wait for the first note to sound.
  task automatic wait_note(input string tag);
    int n = 0;
    while (note_div == 22'd0 && n < 3) begin
      step();
      n++;
    end
    check(tag, {63'd0, note_div != 22'd0}, 64'd1);
  endtask

  // Check n consecutive cycles against one expected output set.
  task automatic span(input string tag, input int n, input logic pl, input logic [4:0] a,
                      input logic [3:0] v, input logic [21:0] d);
    for (int i = 0; i < n; i++) begin
      check(tag, snap(), pack(pl, 1'b0, a, v, d));
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    rom[0] = 8'h62; rom[1] = 8'h01; rom[2] = 8'h83; rom[3] = 8'h00;

    step();
    rst_n = 1'b1;
    step();
    check("reset", snap(), pack(1'b0, 1'b0, 5'd0, 4'd0, 22'd0));

    // Full score: A4 x2 ticks, rest x1, C5 x3, end.
    pulse_play();
    check("fetch0", snap(), pack(1'b1, 1'b0, 5'd0, 4'd0, 22'd0));
    wait_note("a4_start");
    span("a4",   8,  1'b1, 5'd0, 4'd8, c_div_a4);
    span("gap1", 2,  1'b1, 5'd1, 4'd8, c_div_a4);
    span("rest", 4,  1'b1, 5'd1, 4'd0, 22'd0);
    span("gap2", 2,  1'b1, 5'd2, 4'd0, 22'd0);
    span("c5",   12, 1'b1, 5'd2, 4'd8, c_div_c5);
    span("gap3", 2,  1'b1, 5'd3, 4'd8, c_div_c5);
`ifdef MUSIC_LOOP_EN
    check("done", snap(), pack(1'b1, 1'b1, 5'd0, 4'd0, 22'd0));
    pulse_stop();
`else
    check("done", snap(), pack(1'b0, 1'b1, 5'd0, 4'd0, 22'd0));
    step();
    check("idle_after_done", snap(), pack(1'b0, 1'b0, 5'd0, 4'd0, 22'd0));
`endif

    // Pause three cycles into A4, resume for the remaining five.
    pulse_play();
    wait_note("p_start");
    span("p_a4a", 2, 1'b1, 5'd0, 4'd8, c_div_a4);
    play_btn = 1'b1;
    check("p_a4c3", snap(), pack(1'b1, 1'b0, 5'd0, 4'd8, c_div_a4));
    step();
    play_btn = 1'b0;
    span("pause", 3, 1'b0, 5'd0, 4'd0, c_div_a4);
    pulse_play();
    span("p_a4b",  5, 1'b1, 5'd0, 4'd8, c_div_a4);
    span("p_gap1", 2, 1'b1, 5'd1, 4'd8, c_div_a4);
    span("p_rest", 4, 1'b1, 5'd1, 4'd0, 22'd0);
    span("p_gap2", 2, 1'b1, 5'd2, 4'd0, 22'd0);
    span("p_c5",   3, 1'b1, 5'd2, 4'd8, c_div_c5);

    // Stop and play together during C5: stop wins, no done pulse.
    play_btn = 1'b1; stop_btn = 1'b1;
    step();
    play_btn = 1'b0; stop_btn = 1'b0;
    check("stop", snap(), pack(1'b0, 1'b0, 5'd0, 4'd0, 22'd0));
    span("stop_idle", 4, 1'b0, 5'd0, 4'd0, 22'd0);

    // Volume saturation and same-cycle up/down.
    do_reset();
    vol_up = 1'b1;
    repeat (10) step();
    vol_up = 1'b0;
    pulse_play();
    wait_note("v_start");
    check("vol_sat", snap(), pack(1'b1, 1'b0, 5'd0, 4'd15, c_div_a4));
    vol_up = 1'b1; vol_down = 1'b1;
    step();
    vol_up = 1'b0; vol_down = 1'b0;
    check("vol_both", snap(), pack(1'b1, 1'b0, 5'd0, 4'd15, c_div_a4));
    vol_down = 1'b1;
    step();
    vol_down = 1'b0;
    check("vol_dn_next", snap(), pack(1'b1, 1'b0, 5'd0, 4'd14, c_div_a4));
    pulse_stop();
    vol_down = 1'b1;
    repeat (20) step();
    vol_down = 1'b0;
    vol_up = 1'b1;
    step();
    vol_up = 1'b0;
    pulse_play();
    wait_note("v0_start");
    check("vol_floor", snap(), pack(1'b1, 1'b0, 5'd0, 4'd1, c_div_a4));

    // Asynchronous reset mid-note.
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", snap(), pack(1'b0, 1'b0, 5'd0, 4'd0, 22'd0));
    step();
    rst_n = 1'b1;
    step();
    pulse_play();
    wait_note("r_start");
    check("rst_vol", snap(), pack(1'b1, 1'b0, 5'd0, 4'd8, c_div_a4));
    pulse_stop();

    // Whole address space of one-tick C4 notes.
    for (int i = 0; i < 32; i++) rom[i] = 8'h11;
    pulse_play();
    wait_note("c4_start");
    for (int a = 0; a < 32; a++) begin
      span("c4", c_tick, 1'b1, 5'(a), 4'd8, c_div_c4);
      if (a < 31) span("c4_gap", 2, 1'b1, 5'(a + 1), 4'd8, c_div_c4);
    end
`ifdef MUSIC_LOOP_EN
    check("c4_done", snap(), pack(1'b1, 1'b1, 5'd0, 4'd0, 22'd0));
    step();
    step();
    check("loop_restart", snap(), pack(1'b1, 1'b0, 5'd0, 4'd8, c_div_c4));
    pulse_stop();
    check("loop_stop", snap(), pack(1'b0, 1'b0, 5'd0, 4'd0, 22'd0));
`else
    check("c4_done", snap(), pack(1'b0, 1'b1, 5'd0, 4'd0, 22'd0));
    step();
    check("c4_idle", snap(), pack(1'b0, 1'b0, 5'd0, 4'd0, 22'd0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
